// File: rtl/key_debounce_scheduler.sv
// Debounces NKEYS raw key inputs using one settle timer that is granted to
// pending keys in round-robin order. Each validated press gives a one-cycle pulse.
module key_debounce_scheduler #(
    parameter int NKEYS  = 4,
    parameter int SETTLE = 2000000,
    parameter int CNT_W  = 21,
    parameter int ID_W   = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [NKEYS-1:0] key,
    output logic [NKEYS-1:0] key_pulse,
    output logic [NKEYS-1:0] pending,
    output logic             busy,
    output logic [ID_W-1:0]  active_id
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [NKEYS-1:0] s1;
    logic [NKEYS-1:0] s2;
    logic [NKEYS-1:0] s3;
    logic [NKEYS-1:0] rise;
    logic [NKEYS-1:0] pending_nxt;
    logic [NKEYS-1:0] pulse_nxt;
    logic [CNT_W-1:0] timer;
    logic [ID_W-1:0]  last_id;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  idx;
    logic             grant_vld;
    logic             retrig;
    logic             timer_done;

    assign rise       = s2 & ~s3;
    assign retrig     = (state == ST_SETTLE) && rise[active_id];
    assign timer_done = (timer == CNT_W'(SETTLE - 1));

    // Input synchronizer plus history stage for edge detection
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= key;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Descending scan so the nearest pending key after last_id wins
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = '0;
        for (int k = NKEYS; k >= 1; k--) begin
            idx = ID_W'((int'(last_id) + k) % NKEYS);
            if (pending[idx]) begin
                grant_vld = 1'b1;
                grant_id  = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (grant_vld) state_nxt = ST_SETTLE;
            ST_SETTLE: if (!retrig && timer_done) state_nxt = ST_CHECK;
            ST_CHECK:  state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        pulse_nxt = '0;
        if (state == ST_CHECK && s2[active_id])
            pulse_nxt[active_id] = 1'b1;
    end

    // Set after clear, so a rise in the grant cycle keeps the request alive
    always_comb begin
        pending_nxt = pending;
        if (state == ST_IDLE && grant_vld)
            pending_nxt[grant_id] = 1'b0;
        for (int i = 0; i < NKEYS; i++) begin
            if (rise[i] && !(state == ST_SETTLE && active_id == ID_W'(i)))
                pending_nxt[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pending   <= '0;
            key_pulse <= '0;
            timer     <= '0;
            active_id <= '0;
            last_id   <= ID_W'(NKEYS - 1);
        end else begin
            pending   <= pending_nxt;
            key_pulse <= pulse_nxt;
            case (state)
                ST_IDLE: begin
                    if (grant_vld) begin
                        active_id <= grant_id;
                        timer     <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (retrig)
                        timer <= '0;
                    else if (!timer_done)
                        timer <= timer + CNT_W'(1);
                end
                ST_CHECK: last_id <= active_id;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_key_debounce_scheduler.sv
// Directed bench for key_debounce_scheduler with SETTLE=8, NKEYS=4.
// Edges are counted from the step where a key changes (E0); outputs sampled 1 time unit after each edge.
module tb_key_debounce_scheduler;

    logic       clk;
    logic       clr;
    logic [3:0] key;
    logic [3:0] key_pulse;
    logic [3:0] pending;
    logic       busy;
    logic [1:0] active_id;

    int n_asserts = 0;
    int n_fail    = 0;

    key_debounce_scheduler #(
        .NKEYS(4), .SETTLE(8), .CNT_W(4), .ID_W(2)
    ) dut (
        .clk(clk), .clr(clr), .key(key), .key_pulse(key_pulse),
        .pending(pending), .busy(busy), .active_id(active_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        key = 4'b0000;
        clr = 1'b0;
        #2 clr = 1'b1;
        tick(); tick();
        chk("rst_pulse",  32'(key_pulse), 32'h0);
        chk("rst_pend",   32'(pending),   32'h0);
        chk("rst_busy",   32'(busy),      32'h0);
        chk("rst_active", 32'(active_id), 32'h0);
        clr = 1'b0;
        tick(); tick();

        // Single clean press of key 2
        key[2] = 1'b1;
        tick(); tick(); tick();
        chk("t1_pend_set", 32'(pending), 32'h4);
        chk("t1_idle",     32'(busy),    32'h0);
        tick();
        chk("t1_busy_on", 32'(busy),      32'h1);
        chk("t1_active",  32'(active_id), 32'h2);
        chk("t1_pend_clr", 32'(pending),  32'h0);
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("t1_busy_hold", 32'(busy),      32'h1);
            chk("t1_no_pulse",  32'(key_pulse), 32'h0);
        end
        tick();
        chk("t1_pulse",    32'(key_pulse), 32'h4);
        chk("t1_busy_off", 32'(busy),      32'h0);
        chk("t1_pend_end", 32'(pending),   32'h0);
        tick();
        chk("t1_pulse_end", 32'(key_pulse), 32'h0);
        key[2] = 1'b0;
        repeat (4) tick();

        // Key 1 released before its check: no pulse
        key[1] = 1'b1;
        tick(); tick(); tick();
        chk("t2_pend_set", 32'(pending), 32'h2);
        key[1] = 1'b0;
        tick();
        chk("t2_active", 32'(active_id), 32'h1);
        chk("t2_busy",   32'(busy),      32'h1);
        for (int c = 0; c < 9; c++) begin
            tick();
            chk("t2_no_pulse", 32'(key_pulse), 32'h0);
        end
        chk("t2_idle", 32'(busy),    32'h0);
        chk("t2_pend", 32'(pending), 32'h0);
        tick();
        chk("t2_no_pulse_after", 32'(key_pulse), 32'h0);
        repeat (2) tick();

        // Key 0 bounces during its settle window: timer restarts
        key[0] = 1'b1;
        tick(); tick(); tick(); tick();
        chk("t3_active", 32'(active_id), 32'h0);
        chk("t3_busy",   32'(busy),      32'h1);
        key[0] = 1'b0;
        tick(); tick();
        key[0] = 1'b1;
        for (int c = 0; c < 11; c++) begin
            tick();
            chk("t3_no_pulse", 32'(key_pulse), 32'h0);
            chk("t3_busy",     32'(busy),      32'h1);
            chk("t3_no_pend",  32'(pending),   32'h0);
        end
        tick();
        chk("t3_pulse",    32'(key_pulse), 32'h1);
        chk("t3_idle",     32'(busy),      32'h0);
        chk("t3_pend_end", 32'(pending),   32'h0);
        key[0] = 1'b0;
        repeat (4) tick();

        // Keys 0 and 3 together after last_id=0: key 3 first
        key = 4'b1001;
        tick(); tick(); tick(); tick();
        chk("t4_first_id", 32'(active_id), 32'h3);
        chk("t4_pend_0",   32'(pending),   32'h1);
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("t4_no_pulse_a", 32'(key_pulse), 32'h0);
        end
        tick();
        chk("t4_pulse3", 32'(key_pulse), 32'h8);
        chk("t4_pend_0b", 32'(pending),  32'h1);
        chk("t4_idle",   32'(busy),      32'h0);
        tick();
        chk("t4_second_id", 32'(active_id), 32'h0);
        chk("t4_busy2",     32'(busy),      32'h1);
        chk("t4_pend_clr",  32'(pending),   32'h0);
        chk("t4_pulse_gap", 32'(key_pulse), 32'h0);
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("t4_no_pulse_b", 32'(key_pulse), 32'h0);
        end
        tick();
        chk("t4_pulse0", 32'(key_pulse), 32'h1);
        key = 4'b0000;
        repeat (4) tick();

        // Reset mid-settle with key 1 active and key 2 pending
        key = 4'b0010;
        tick(); tick(); tick(); tick();
        chk("t5_active", 32'(active_id), 32'h1);
        key[2] = 1'b1;
        tick(); tick(); tick(); tick();
        chk("t5_pend2",   32'(pending),   32'h4);
        chk("t5_busy",    32'(busy),      32'h1);
        chk("t5_active2", 32'(active_id), 32'h1);
        clr = 1'b1;
        key = 4'b0000;
        #1;
        chk("t5_clr_pulse",  32'(key_pulse), 32'h0);
        chk("t5_clr_pend",   32'(pending),   32'h0);
        chk("t5_clr_busy",   32'(busy),      32'h0);
        chk("t5_clr_active", 32'(active_id), 32'h0);
        tick(); tick();
        clr = 1'b0;
        for (int c = 0; c < 14; c++) begin
            tick();
            chk("t5_quiet_pulse", 32'(key_pulse), 32'h0);
            chk("t5_quiet_busy",  32'(busy),      32'h0);
        end

        // Key 2 re-rises on the cycle it is granted: served twice
        key = 4'b0010;
        tick(); tick(); tick(); tick();
        chk("t6_active1", 32'(active_id), 32'h1);
        key[2] = 1'b1;
        tick(); tick(); tick();
        chk("t6_pend2", 32'(pending), 32'h4);
        key[2] = 1'b0;
        tick(); tick(); tick(); tick();
        key[2] = 1'b1;
        tick(); tick();
        chk("t6_pulse1",  32'(key_pulse), 32'h2);
        chk("t6_pend2b",  32'(pending),   32'h4);
        tick();
        chk("t6_pend_kept", 32'(pending),   32'h4);
        chk("t6_active2",   32'(active_id), 32'h2);
        chk("t6_busy",      32'(busy),      32'h1);
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("t6_no_pulse_a", 32'(key_pulse), 32'h0);
        end
        tick();
        chk("t6_pulse2a", 32'(key_pulse), 32'h4);
        chk("t6_pend_c",  32'(pending),   32'h4);
        chk("t6_idle",    32'(busy),      32'h0);
        tick();
        chk("t6_regrant",  32'(active_id), 32'h2);
        chk("t6_busy2",    32'(busy),      32'h1);
        chk("t6_pend_clr", 32'(pending),   32'h0);
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("t6_no_pulse_b", 32'(key_pulse), 32'h0);
        end
        tick();
        chk("t6_pulse2b", 32'(key_pulse), 32'h4);
        key = 4'b0000;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
